// File: rtl/spi_frame_tx_if.sv
// Signal bundle between the SPI frame transmitter and its user.
// The master modport is the transmitter; the slave modport is the logic that feeds it frames.
interface spi_frame_tx_if #(
  parameter int FRAME_W = 48
);
  logic               start;
  logic [FRAME_W-1:0] data_in;
  logic               busy;
  logic               done;
  logic               sck;
  logic               sdo;
  logic               cs;

  modport master (input start, data_in, output busy, done, sck, sdo, cs);
  modport slave  (output start, data_in, input busy, done, sck, sdo, cs);
endinterface

// File: rtl/spi_frame_tx.sv
// SPI mode-0 controller transmitter: captures a parallel frame on start and shifts it out
// MSB first, with cs/sck generated from clk_in and every output driven from a flop.
module spi_frame_tx #(
  parameter int NUM_WORDS = 3,
  parameter int WORD_W    = 16,
  parameter int CLK_DIV   = 2,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  spi_frame_tx_if.master  bus
);
  localparam int FRAME_W = NUM_WORDS * WORD_W;
  localparam int BIT_W   = $clog2(FRAME_W + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);
  localparam int GAP_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);

  localparam logic [BIT_W-1:0] BIT_FULL   = BIT_W'(FRAME_W);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [GAP_W-1:0] SETUP_LAST = GAP_W'(CS_SETUP - 1);
  localparam logic [GAP_W-1:0] HOLD_LAST  = GAP_W'(CS_HOLD - 1);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t             r_state,   w_state;
  logic [FRAME_W-1:0] r_shift,   w_shift;
  logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt;
  logic [DIV_W-1:0]   r_div_cnt, w_div_cnt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt;
  logic               r_cs,   w_cs;
  logic               r_sck,  w_sck;
  logic               r_sdo,  w_sdo;
  logic               r_busy, w_busy;
  logic               r_done, w_done;

  // NOTE: every flop here, shift register included, is reset so an abandoned frame leaves no trace.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_gap_cnt <= '0;
      r_cs      <= 1'b1;
      r_sck     <= 1'b0;
      r_sdo     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_shift   <= w_shift;
      r_bit_cnt <= w_bit_cnt;
      r_div_cnt <= w_div_cnt;
      r_gap_cnt <= w_gap_cnt;
      r_cs      <= w_cs;
      r_sck     <= w_sck;
      r_sdo     <= w_sdo;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  // NOTE: each next value defaults to "hold" before the case, so no path can infer a latch.
  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift;
    w_bit_cnt = r_bit_cnt;
    w_div_cnt = r_div_cnt;
    w_gap_cnt = r_gap_cnt;
    w_cs      = r_cs;
    w_sck     = r_sck;
    w_sdo     = r_sdo;
    w_busy    = r_busy;
    w_done    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cs   = 1'b1;
        w_sck  = 1'b0;
        w_sdo  = 1'b0;
        w_busy = 1'b0;
        if (bus.start) begin
          w_state   = S_SETUP;
          w_shift   = bus.data_in;
          w_cs      = 1'b0;
          w_busy    = 1'b1;
          w_sdo     = bus.data_in[FRAME_W-1];
          w_gap_cnt = SETUP_LAST;
        end
      end

      S_SETUP: begin
        if (r_gap_cnt == '0) begin
          w_state   = S_SHIFT;
          w_div_cnt = DIV_LAST;
          w_bit_cnt = BIT_FULL;
        end else begin
          w_gap_cnt = r_gap_cnt - GAP_ONE;
        end
      end

      S_SHIFT: begin
        if (r_div_cnt != '0) begin
          w_div_cnt = r_div_cnt - DIV_ONE;
        end else if (!r_sck) begin
          w_sck     = 1'b1;
          w_div_cnt = DIV_LAST;
        end else begin
          // End of a high phase: sck falls and sdo moves on, unless that was the last bit.
          w_sck = 1'b0;
          if (r_bit_cnt == BIT_ONE) begin
            w_state   = S_HOLD;
            w_gap_cnt = HOLD_LAST;
          end else begin
            w_bit_cnt = r_bit_cnt - BIT_ONE;
            w_shift   = r_shift << 1;
            w_sdo     = r_shift[FRAME_W-2];
            w_div_cnt = DIV_LAST;
          end
        end
      end

      S_HOLD: begin
        if (r_gap_cnt == '0) begin
          w_state = S_IDLE;
          w_cs    = 1'b1;
          w_sdo   = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_gap_cnt = r_gap_cnt - GAP_ONE;
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sck  = r_sck;
  assign bus.sdo  = r_sdo;
  assign bus.cs   = r_cs;
endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: a scoreboard of expected frames against an sck-rising sampler,
// plus a second instance with minimum timing parameters for the cs/sck spacing checks.
module tb_spi_frame_tx;
  localparam int FW = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  spi_frame_tx_if #(.FRAME_W(FW)) bus_a ();
  spi_frame_tx_if #(.FRAME_W(FW)) bus_b ();

  spi_frame_tx dut_a (
    .clk_in (clk),
    .rst_in (rst_a),
    .bus    (bus_a)
  );

  spi_frame_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) dut_b (
    .clk_in (clk),
    .rst_in (rst_b),
    .bus    (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and monitor for instance A
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cap_a;
  logic          prev_cs = 1'b1;
  logic          prev_sck = 1'b0;
  logic          in_frame = 1'b0;
  int            rises_a = 0;
  int            busy_cyc = 0;
  int            frames_a = 0;
  int            done_cnt = 0;
  int            cs_run = 0;
  int            last_gap = 0;

  always @(negedge clk) begin
    if (rst_a) begin
      in_frame = 1'b0;
      prev_cs  = 1'b1;
      prev_sck = 1'b0;
      cs_run   = 0;
    end else begin
      if (bus_a.done) done_cnt++;
      if (!bus_a.cs && prev_cs) begin
        in_frame = 1'b1;
        cap_a    = '0;
        rises_a  = 0;
        busy_cyc = 0;
        last_gap = cs_run;
      end
      if (in_frame && bus_a.busy) busy_cyc++;
      if (in_frame && bus_a.sck && !prev_sck) begin
        cap_a = {cap_a[FW-2:0], bus_a.sdo};
        rises_a++;
      end
      if (in_frame && bus_a.cs && !prev_cs) begin
        in_frame = 1'b0;
        frames_a++;
        check("end_done", 64'(bus_a.done), 64'(1));
        check("end_busy", 64'(bus_a.busy), 64'(0));
        check("sck_rises", 64'(rises_a), 64'(FW));
        check("busy_cycles", 64'(busy_cyc), 64'(196));
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          logic [FW-1:0] e;
          e = exp_q.pop_front();
          check("frame_data", 64'(cap_a), 64'(e));
        end
      end
      cs_run   = bus_a.cs ? cs_run + 1 : 0;
      prev_cs  = bus_a.cs;
      prev_sck = bus_a.sck;
    end
  end

  task automatic send_a(input logic [FW-1:0] d, input bit expect_it);
    @(posedge clk);
    #1;
    bus_a.start   = 1'b1;
    bus_a.data_in = d;
    if (expect_it) exp_q.push_back(d);
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_a < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 64'(frames_a >= target), 64'(1));
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises_a < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rise_timeout", 64'(rises_a >= target), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.start = 1'b0;
    bus_a.data_in = '0;
    bus_b.start = 1'b0;
    bus_b.data_in = '0;

    // 1: reset state, no sck activity
    repeat (3) begin
      @(negedge clk);
      check("reset_outs", 64'({bus_a.cs, bus_a.sck, bus_a.sdo, bus_a.busy, bus_a.done}),
            64'(5'b10000));
    end
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // 2: basic frame
    send_a(48'h1234_ABCD_8001, 1'b1);
    wait_frames(1);
    check("done_count_t2", 64'(done_cnt), 64'(1));

    // 3: start while busy is ignored
    send_a(48'hFFFF_0000_A5A5, 1'b1);
    wait_rises(10);
    @(posedge clk);
    #1;
    bus_a.start   = 1'b1;
    bus_a.data_in = '0;
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    wait_frames(2);
    repeat (30) @(negedge clk);
    check("frames_t3", 64'(frames_a), 64'(2));
    check("done_count_t3", 64'(done_cnt), 64'(2));
    check("idle_t3", 64'({bus_a.cs, bus_a.busy}), 64'(2'b10));

    // 4: start accepted in the done cycle, single-cycle cs gap
    send_a(48'h0000_0000_0001, 1'b1);
    n = 0;
    while (!bus_a.done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen_t4", 64'(bus_a.done), 64'(1));
    bus_a.start   = 1'b1;
    bus_a.data_in = 48'h8000_0000_0000;
    exp_q.push_back(48'h8000_0000_0000);
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
    wait_frames(4);
    check("cs_gap_t4", 64'(last_gap), 64'(1));

    // 5: asynchronous reset mid-frame abandons the frame
    send_a(48'hC3C3_5A5A_F00F, 1'b0);
    wait_rises(20);
    @(posedge clk);
    #3;
    rst_a = 1'b1;
    #1;
    check("abort_cs_sck", 64'({bus_a.cs, bus_a.sck, bus_a.busy}), 64'(3'b100));
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", 64'(bus_a.done), 64'(0));
    end
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    repeat (5) @(negedge clk);
    check("done_count_t5", 64'(done_cnt), 64'(4));
    check("frames_t5", 64'(frames_a), 64'(4));
    send_a(48'hDEAD_BEEF_0F0F, 1'b1);
    wait_frames(5);
    check("sb_left", 64'(exp_q.size()), 64'(0));

    // 6: minimum timing on instance B
    begin
      int t = 0;
      int t_cs_lo = -1;
      int t_rise = -1;
      int t_last_hi = -1;
      int t_cs_hi = -1;
      int nb = 0;
      int rb = 0;
      logic [FW-1:0] capb = '0;
      logic psck = 1'b0;
      @(posedge clk);
      #1;
      bus_b.start   = 1'b1;
      bus_b.data_in = 48'h5A5A_0FF0_C3C1;
      @(posedge clk);
      #1;
      bus_b.start   = 1'b0;
      bus_b.data_in = '0;
      while (t_cs_hi < 0 && t < 400) begin
        @(negedge clk);
        t++;
        if (bus_b.busy) nb++;
        if (!bus_b.cs && t_cs_lo < 0) t_cs_lo = t;
        if (bus_b.sck) begin
          if (t_rise < 0) t_rise = t;
          t_last_hi = t;
          if (!psck) begin
            capb = {capb[FW-2:0], bus_b.sdo};
            rb++;
          end
        end
        psck = bus_b.sck;
        if (bus_b.cs && t_cs_lo >= 0) begin
          t_cs_hi = t;
          check("b_done", 64'(bus_b.done), 64'(1));
        end
      end
      check("b_timeout", 64'(t_cs_hi > 0), 64'(1));
      check("b_cs_to_rise", 64'(t_rise - t_cs_lo), 64'(2));
      check("b_fall_to_cs", 64'(t_cs_hi - t_last_hi), 64'(2));
      check("b_busy_cycles", 64'(nb), 64'(98));
      check("b_rises", 64'(rb), 64'(FW));
      check("b_frame_data", 64'(capb), 64'(48'h5A5A_0FF0_C3C1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
